// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encoding, FSM state type and constants for the
//               EX-stage HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

    // Ops 0-3 start the iterative core; 4-7 are HI/LO moves.
    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_core
// Description : Radix-2 unsigned shift-add multiplier / restoring divider.
//               res_next is the {hi,lo} pair after applying the current step.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res_next
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_b;
    logic        r_div;
    logic [32:0] w_sum;
    logic [32:0] w_rem;
    logic        w_ge;

    // A zero divisor needs no special case: every trial subtract succeeds,
    // so the quotient fills with ones and the dividend shifts into hi.
    always_comb begin
        w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
        w_rem = {r_hi, r_lo[31]};
        w_ge  = (w_rem >= {1'b0, r_b});
        if (r_div) begin
            res_next = {(w_ge ? (w_rem[31:0] - r_b) : w_rem[31:0]), r_lo[30:0], w_ge};
        end else begin
            res_next = {w_sum, r_lo[31:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (load) begin
            r_hi  <= '0;
            r_lo  <= a;
            r_b   <= b;
            r_div <= is_div;
        end else if (step) begin
            {r_hi, r_lo} <= res_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : EX-stage HI/LO unit: FSM, HI/LO registers and stall/forward
//               logic around muldiv_core. Define MULDIV_SIGNED_EN for signed
//               MULT/DIV; otherwise ops 0/2 behave as MULTU/DIVU.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_valid
);

    state_t      r_state;
    state_t      w_state_nxt;
    op_t         w_op;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_arith;
    logic        w_accept;
    logic        w_last;
    logic        w_step;
    logic        w_mf;
    logic        w_mt;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [63:0] w_core_nxt;
    logic [63:0] w_final;

    assign w_op    = op_t'(op);
    assign w_arith = is_arith(op);
    assign w_step  = (r_state == ST_RUN);
    assign w_mf    = start & ((w_op == OP_MFHI) | (w_op == OP_MFLO));
    assign w_mt    = start & ~flush & (r_state != ST_RUN) &
                     ((w_op == OP_MTHI) | (w_op == OP_MTLO));

`ifdef MULDIV_SIGNED_EN
    logic w_sop;
    logic r_div;
    logic r_neg_q;
    logic r_neg_r;
    logic r_div0;

    assign w_sop = ~op[0];
    assign w_a   = (w_sop & rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
    assign w_b   = (w_sop & rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
        end else if (w_accept) begin
            r_div   <= op[1];
            r_neg_q <= w_sop & (rs_val[31] ^ rt_val[31]);
            r_neg_r <= w_sop & rs_val[31];
            r_div0  <= (rt_val == 32'd0);
        end
    end

    // Remainder follows the dividend sign; a zero divisor keeps the all-ones quotient.
    always_comb begin
        w_final = w_core_nxt;
        if (r_div) begin
            w_final[63:32] = r_neg_r ? (~w_core_nxt[63:32] + 32'd1) : w_core_nxt[63:32];
            w_final[31:0]  = r_div0  ? DIV0_QUOT :
                             (r_neg_q ? (~w_core_nxt[31:0] + 32'd1) : w_core_nxt[31:0]);
        end else if (r_neg_q) begin
            w_final = ~w_core_nxt + 64'd1;
        end
    end
`else
    assign w_a     = rs_val;
    assign w_b     = rt_val;
    assign w_final = w_core_nxt;
`endif

    muldiv_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept),
        .step     (w_step),
        .is_div   (op[1]),
        .a        (w_a),
        .b        (w_b),
        .res_next (w_core_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        stall        = 1'b0;
        result_valid = 1'b0;
        result       = '0;
        case (r_state)
            ST_IDLE: begin
                if (start & w_arith) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                stall = start;
                if (r_cnt == 5'(ITER_COUNT - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // A new mul/div can only be accepted from IDLE, so hold it one more cycle.
                stall       = start & w_arith;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_accept    = 1'b0;
            w_last      = 1'b0;
        end
        if (w_mf && (r_state != ST_RUN)) begin
            result_valid = 1'b1;
            result       = op[0] ? r_lo : r_hi;
        end
        if (!rst) begin
            stall        = 1'b0;
            result_valid = 1'b0;
            result       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_final[63:32];
            r_lo <= w_final[31:0];
        end else if (w_mt) begin
            if (op[0]) begin
                r_lo <= rs_val;
            end else begin
                r_hi <= rs_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Directed self-checking bench for ex_muldiv with an expected
//               HI/LO model and a read-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        busy;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .flush        (flush),
        .busy         (busy),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int n;
        do_op(o, a, b);
        wait_busy(n);
        check({tag, "_busy_cycles"}, 64'(n), 64'd32);
    endtask

    task automatic arith_u(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        logic [63:0] p;
        run_op(o, a, b, tag);
        if (o[1]) begin
            if (b == 32'd0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = a;
            end else begin
                m_lo = a / b;
                m_hi = a % b;
            end
        end else begin
            p = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
        end
    endtask

    task automatic mf_read(input bit lo_sel, input string tag, output int stalls, output int bad);
        logic [31:0] exp;
        bit          got;
        sb.push_back(lo_sel ? m_lo : m_hi);
        @(posedge clk); #1;
        start = 1'b1;
        op    = lo_sel ? 3'd5 : 3'd4;
        stalls = 0;
        bad    = 0;
        got    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1;
                break;
            end
            if (stall) stalls++;
            if (result !== 32'd0) bad = 1;
            @(posedge clk); #1;
        end
        exp = sb.pop_front();
        if (!got) check({tag, "_timeout"}, 64'(result_valid), 64'd1);
        else      check(tag, 64'(result), 64'(exp));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic mf_expect(input bit lo_sel, input string tag);
        int s;
        int b;
        mf_read(lo_sel, tag, s, b);
    endtask

    initial begin
        int          n;
        int          bad;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b0; start = 1'b1; op = 3'd4; flush = 1'b0;
        rs_val = '0; rt_val = '0; m_hi = '0; m_lo = '0;
        #12;
        check("rst_busy",   64'(busy),         64'd0);
        check("rst_stall",  64'(stall),        64'd0);
        check("rst_rvalid", 64'(result_valid), 64'd0);
        check("rst_result", 64'(result),       64'd0);
        start = 1'b0;
        #10 rst = 1'b1;
        mf_expect(1'b0, "reset_hi");
        mf_expect(1'b1, "reset_lo");

        arith_u(3'd1, 32'hFFFF_FFFF, 32'd2, "multu_max");
        mf_expect(1'b0, "multu_max_hi");
        mf_expect(1'b1, "multu_max_lo");

        // MFLO issued five cycles into the divide must stall until DONE.
        do_op(3'd3, 32'd100, 32'd7);
        m_lo = 32'd14;
        m_hi = 32'd2;
        repeat (4) @(posedge clk);
        mf_read(1'b1, "divu_early_mflo", n, bad);
        check("divu_early_stalls", 64'(n), 64'd27);
        check("divu_early_res0", 64'(bad), 64'd0);
        mf_expect(1'b0, "divu_100_7_hi");

        arith_u(3'd3, 32'd5, 32'd0, "divu_zero");
        mf_expect(1'b1, "divu_zero_lo");
        mf_expect(1'b0, "divu_zero_hi");

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
`ifdef MULDIV_SIGNED_EN
        m_lo = 32'hFFFF_FFFD;
        m_hi = 32'hFFFF_FFFF;
`else
        m_lo = 32'h7FFF_FFFC;
        m_hi = 32'd1;
`endif
        mf_expect(1'b1, "div_m7_2_lo");
        mf_expect(1'b0, "div_m7_2_hi");

        run_op(3'd0, 32'hFFFF_FFFD, 32'd4, "mult_m3_4");
`ifdef MULDIV_SIGNED_EN
        m_hi = 32'hFFFF_FFFF;
`else
        m_hi = 32'd3;
`endif
        m_lo = 32'hFFFF_FFF4;
        mf_expect(1'b0, "mult_m3_4_hi");
        mf_expect(1'b1, "mult_m3_4_lo");

        do_op(3'd7, 32'h0000_A5A5, 32'd0);
        m_lo = 32'h0000_A5A5;
        do_op(3'd1, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #1;
        check("run_before_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_to_idle", 64'(busy), 64'd0);
        mf_expect(1'b1, "flush_lo");
        mf_expect(1'b0, "flush_hi");

        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; rs_val = 32'd9; rt_val = 32'd9; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_wins_start", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b1; op = 3'd6; rs_val = 32'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        mf_expect(1'b0, "flush_wins_mthi");

        do_op(3'd6, 32'h1357_9BDF, 32'd0);
        m_hi = 32'h1357_9BDF;
        mf_expect(1'b0, "mthi_hi");

        do_op(3'd1, 32'd1000, 32'd1000);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1; op = 3'd4;
        #1;
        check("midrun_stall", 64'(stall), 64'd1);
        rst = 1'b0;
        #1;
        check("midrun_rst_busy",   64'(busy),         64'd0);
        check("midrun_rst_stall",  64'(stall),        64'd0);
        check("midrun_rst_rvalid", 64'(result_valid), 64'd0);
        check("midrun_rst_result", 64'(result),       64'd0);
        start = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        mf_expect(1'b0, "post_rst_hi");
        mf_expect(1'b1, "post_rst_lo");
        arith_u(3'd1, 32'd3, 32'd3, "multu_3x3");
        mf_expect(1'b1, "multu_3x3_lo");
        mf_expect(1'b0, "multu_3x3_hi");

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            arith_u(3'd1, ra, rb, "rand_multu");
            mf_expect(1'b0, "rand_multu_hi");
            mf_expect(1'b1, "rand_multu_lo");
            rb = 32'($urandom_range(1, 65535));
            arith_u(3'd3, ra, rb, "rand_divu");
            mf_expect(1'b1, "rand_divu_lo");
            mf_expect(1'b0, "rand_divu_hi");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
